// File: rtl/adpll_lock_ctrl.sv
// ADPLL loop controller: synchronises the PFD up/down flags, runs a SAR frequency
// search on the DCO code, then +/-1 phase tracking with lock / unlock qualification.
module adpll_lock_ctrl #(
  parameter int CODE_W     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_THR = 4
) (
  input  logic              IN_clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              flagU,
  input  logic              flagD,
  output logic [CODE_W-1:0] dco_code,
  output logic [1:0]        state,
  output logic              locked
);

  localparam int KW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_THR + 1);

  localparam logic [CODE_W-1:0] MID    = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [KW-1:0]     K_TOP  = KW'(CODE_W - 1);
  localparam logic [SW-1:0]     S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [LW-1:0]     L_TGT  = LW'(LOCK_CNT);
  localparam logic [UW-1:0]     U_TGT  = UW'(UNLOCK_THR);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2, LOCK = 2'd3} st_t;

  st_t               st, st_n;
  logic [CODE_W-1:0] code, code_n;
  logic [KW-1:0]     k, k_n;
  logic [SW-1:0]     cnt, cnt_n;
  logic [LW-1:0]     lock_cnt, lock_n;
  logic [UW-1:0]     same_cnt, same_n;
  logic [1:0]        last_dir, last_n;
  logic              flag_u_p1, flag_u_p2, flag_d_p1, flag_d_p2;
  logic              up, dn, tick;
  logic [1:0]        dir;

  // Saturating +/-1 step so the DCO code can never wrap.
  function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] c,
                                                  input logic u, input logic d);
    logic [CODE_W-1:0] r;
    r = c;
    if (u && (c != {CODE_W{1'b1}})) r = c + 1'b1;
    else if (d && (c != '0))        r = c - 1'b1;
    return r;
  endfunction

  assign up   = flag_u_p2 & ~flag_d_p2;
  assign dn   = flag_d_p2 & ~flag_u_p2;
  assign dir  = up ? DIR_UP : (dn ? DIR_DN : DIR_NONE);
  assign tick = (cnt == S_LAST);

  always_comb begin
    st_n   = st;
    code_n = code;
    k_n    = k;
    cnt_n  = tick ? '0 : cnt + 1'b1;
    lock_n = lock_cnt;
    same_n = same_cnt;
    last_n = last_dir;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (enable) begin
          st_n   = SEARCH;
          code_n = MID;
          k_n    = K_TOP;
        end
      end
      SEARCH: if (tick) begin
        if (dn) code_n[k] = 1'b0;
        if (k != '0) begin
          code_n[k - 1'b1] = 1'b1;
          k_n              = k - 1'b1;
        end else begin
          st_n   = TRACK;
          cnt_n  = '0;
          lock_n = '0;
          same_n = '0;
          last_n = DIR_NONE;
        end
      end
      TRACK: if (tick) begin
        code_n = step_code(code, up, dn);
        if ((dir == DIR_NONE) || (last_dir == DIR_NONE) || (dir != last_dir))
          lock_n = (lock_cnt == L_TGT) ? lock_cnt : lock_cnt + 1'b1;
        else
          lock_n = '0;
        if (dir != DIR_NONE) last_n = dir;
        if (lock_n == L_TGT) begin
          st_n   = LOCK;
          cnt_n  = '0;
          same_n = '0;
        end
      end
      LOCK: if (tick) begin
        code_n = step_code(code, up, dn);
        if ((dir != DIR_NONE) && (dir == last_dir))
          same_n = (same_cnt == U_TGT) ? same_cnt : same_cnt + 1'b1;
        else
          same_n = '0;
        if (dir != DIR_NONE) last_n = dir;
        if (same_n == U_TGT) begin
          st_n   = TRACK;
          cnt_n  = '0;
          lock_n = '0;
          same_n = '0;
          last_n = DIR_NONE;
        end
      end
      default: st_n = IDLE;
    endcase
    // Dropping enable aborts whatever the loop was doing.
    if (!enable) begin
      st_n   = IDLE;
      code_n = MID;
      k_n    = K_TOP;
      cnt_n  = '0;
      lock_n = '0;
      same_n = '0;
      last_n = DIR_NONE;
    end
  end

  always_ff @(posedge IN_clk) begin
    if (RESET) begin
      st        <= IDLE;
      code      <= MID;
      k         <= K_TOP;
      cnt       <= '0;
      lock_cnt  <= '0;
      same_cnt  <= '0;
      last_dir  <= DIR_NONE;
      flag_u_p1 <= 1'b0;
      flag_u_p2 <= 1'b0;
      flag_d_p1 <= 1'b0;
      flag_d_p2 <= 1'b0;
    end else begin
      st        <= st_n;
      code      <= code_n;
      k         <= k_n;
      cnt       <= cnt_n;
      lock_cnt  <= lock_n;
      same_cnt  <= same_n;
      last_dir  <= last_n;
      flag_u_p1 <= flagU;
      flag_u_p2 <= flag_u_p1;
      flag_d_p1 <= flagD;
      flag_d_p2 <= flag_d_p1;
    end
  end

  assign dco_code = code;
  assign state    = st;
  assign locked   = (st == LOCK);

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl: SAR acquisition, tracking, lock/unlock,
// code saturation, and enable/reset aborts.
module tb_adpll_lock_ctrl;

  logic       IN_clk = 1'b0;
  logic       RESET, enable, flagU, flagD;
  logic [7:0] dco_code;
  logic [1:0] state;
  logic       locked;

  logic       model_en;
  logic [7:0] target;
  logic       fu, fd;
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 IN_clk = ~IN_clk;

  // PFD model: compares the DCO code with a target frequency, or forced flags.
  assign flagU = model_en ? (dco_code < target) : fu;
  assign flagD = model_en ? (dco_code > target) : fd;

  adpll_lock_ctrl #(.CODE_W(8), .SETTLE_CYC(4), .LOCK_CNT(16), .UNLOCK_THR(4)) dut (
    .IN_clk  (IN_clk),
    .RESET   (RESET),
    .enable  (enable),
    .flagU   (flagU),
    .flagD   (flagD),
    .dco_code(dco_code),
    .state   (state),
    .locked  (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] code, input logic [1:0] st,
                           input logic lk);
    check({tag, ".code"}, 32'(dco_code), 32'(code));
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".locked"}, 32'(locked), 32'(lk));
  endtask

  task automatic wait_change(input string tag);
    logic [7:0] prev;
    bit seen;
    prev = dco_code;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge IN_clk);
      if (dco_code !== prev) seen = 1'b1;
    end
    n_chk++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s: observed no code step within 12 cycles (code 0x%0h) expected a step", tag, dco_code);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge IN_clk);
      if (state === st) seen = 1'b1;
    end
    n_chk++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s: observed state %0d after %0d cycles expected %0d", tag, state, budget, st);
    end
  endtask

  // Alternate dn/up ticks from a TRACK base code; lock expected on the 16th tick (an up).
  task automatic alt_to_lock(input string tag, input logic [7:0] base);
    model_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fd = (i % 2 == 0);
      fu = !fd;
      wait_change(tag);
      if (i < 15) check_out(tag, (i % 2 == 0) ? base - 8'd1 : base, 2'd2, 1'b0);
      else        check_out(tag, base, 2'd3, 1'b1);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    enable   = 1'b1;
    model_en = 1'b1;
    target   = 8'h5A;
    fu       = 1'b0;
    fd       = 1'b0;

    repeat (2) begin
      @(negedge IN_clk);
      check_out("reset", 8'h80, 2'd0, 1'b0);
    end
    RESET = 1'b0;

    @(negedge IN_clk);
    check_out("search_entry", 8'h80, 2'd1, 1'b0);
    wait_change("sar_step1");
    check("sar_step1.code", 32'(dco_code), 32'h40);
    wait_state("sar_done", 2'd2, 40);
    check_out("sar_result", 8'h5A, 2'd2, 1'b0);

    alt_to_lock("lock1", 8'h5A);

    fu = 1'b1;
    fd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_change("unlock");
      if (i < 3) check_out("lock_hold", 8'h5B + 8'(i), 2'd3, 1'b1);
      else       check_out("unlocked", 8'h5E, 2'd2, 1'b0);
    end

    alt_to_lock("lock2", 8'h5E);

    RESET = 1'b1;
    @(negedge IN_clk);
    check_out("reset_mid_lock", 8'h80, 2'd0, 1'b0);
    RESET = 1'b0;

    model_en = 1'b1;
    target   = 8'hFF;
    wait_state("sar_top", 2'd2, 50);
    check_out("sar_top", 8'hFF, 2'd2, 1'b0);
    model_en = 1'b0;
    fu = 1'b1;
    fd = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge IN_clk);
      check("sat_top.code", 32'(dco_code), 32'hFF);
      check("sat_top.locked", 32'(locked), 32'h0);
    end

    enable = 1'b0;
    @(negedge IN_clk);
    check_out("disable", 8'h80, 2'd0, 1'b0);
    enable = 1'b1;
    @(negedge IN_clk);
    check_out("search_again", 8'h80, 2'd1, 1'b0);
    repeat (6) @(negedge IN_clk);
    check_out("mid_search", 8'hC0, 2'd1, 1'b0);
    enable = 1'b0;
    @(negedge IN_clk);
    check_out("abort_search", 8'h80, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
